forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, meaning the number of register read ports checked in parallel.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register address width.
REQ-003 SHALL have parameter DEPTH, default 3, meaning the number of downstream stages tracked (EX, MEM, WB); the legal range is 1..7.
REQ-004 SHALL have parameter LOAD_LAT, default 2, meaning the first tracked stage, counted from 1, whose load data is forwardable; the legal range is 1..DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-008 SHALL have port id_RegWrite, input, 1 bit: the ID instruction writes a register.
REQ-009 SHALL have port id_MemRead, input, 1 bit: the ID instruction is a load.
REQ-010 SHALL have port id_write_addr, input, ADDR_W bits: the destination register of the ID instruction.
REQ-011 SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: the source addresses, packed with port 0 in the LSBs.
REQ-012 SHALL have port flush, input, 1 bit: kill the ID instruction (branch or jump redirect).
REQ-013 SHALL have port fwd_sel, output, NUM_RD*3 bits: the per-port source select; 0 = register file, k = tracked stage k.
REQ-014 SHALL have port stall, output, 1 bit: hold PC and IF/ID this cycle.
REQ-015 SHALL have port bubble, output, 1 bit: a bubble is entering stage 1 this cycle.

Function
REQ-016 SHALL hold a tracker of DEPTH entries, each {valid, RegWrite, MemRead, addr}; entry 1 is the youngest (EX).
REQ-017 SHALL shift entries k to k+1 every cycle, unconditionally (downstream stages never stall); entry DEPTH retires.
REQ-018 SHALL load entry 1 with the ID fields when id_valid & ~stall & ~flush; otherwise SHALL load entry 1 with all-zero (bubble).
REQ-019 SHALL drive bubble = ~(id_valid & ~stall & ~flush).
REQ-020 SHALL, per port p, define "match k" = entry k valid & RegWrite & addr != 0 & addr == rd_addr[p].
REQ-021 SHALL set fwd_sel[p] to the smallest matching k (youngest wins), or 0 if there is none; this path is combinational from the tracker and rd_addr.
REQ-022 SHALL flag port p not-ready when its youngest match k has MemRead = 1 and k < LOAD_LAT; older matches SHALL be ignored.
REQ-023 SHALL assert stall = id_valid & ~flush & (any port not-ready); fwd_sel is don't-care while stall = 1.
REQ-024 SHALL ensure a load-use stall lasts exactly LOAD_LAT - k cycles, after which fwd_sel[p] = LOAD_LAT; stall SHALL never exceed LOAD_LAT - 1 consecutive cycles.
REQ-025 SHALL give flush priority over stall: stall = 0, bubble = 1 and the ID instruction is dropped in that cycle.
REQ-026 SHALL treat register address 0 as never matching, and two ports reading the same address SHALL receive identical selects.

Reset
REQ-027 SHALL, while reset = 0 at a clock edge, clear all tracker entries to zero.
REQ-028 SHALL hold stall = 0, bubble = 1 and fwd_sel = 0 during reset, and SHALL allow no issue during reset.
REQ-029 SHALL, on reset asserted mid-stall, drop the stall at the next edge, with no residual state remaining.

Configuration
REQ-030 SHALL, when FWD_STALL_CNT_EN is defined, add output stall_cnt (32 bits): incremented on every cycle with stall = 1, saturating at all-ones, and cleared by reset.
REQ-031 SHALL, when FWD_STALL_CNT_EN is undefined, have no stall_cnt port and no counter logic.

Structure
REQ-032 SHALL place in package fwd_pkg: the tracker entry struct typedef, the FWD_SEL_W = 3 constant, and the FWD_SEL_RF = 0 constant.
REQ-033 SHALL implement one sub-module, fwd_match, instantiated NUM_RD times: a single-port priority match over the tracker producing sel and not_ready.

Verification
REQ-034 SHALL cover ALU chain: issue add r3 then sub r4,r3,r5 next cycle -> fwd_sel[0] = 1, stall = 0.
REQ-035 SHALL cover load-use with LOAD_LAT = 2: lw r8 followed by add r9,r8,r8 -> stall = 1 for 1 cycle, bubble = 1, then fwd_sel[0] = fwd_sel[1] = 2.
REQ-036 SHALL cover youngest-wins: writes to r6 at stages 1 and 3, read r6 -> fwd_sel = 1; a write to r0 at stage 1 with a read of r0 -> fwd_sel = 0.
REQ-037 SHALL cover flush during a load-use stall: flush = 1 -> stall = 0, bubble = 1, and the dependent op never enters the tracker.
REQ-038 SHALL cover reset pulse (reset = 0 for 1 cycle) mid-stall: next cycle stall = 0, fwd_sel = 0, and stall_cnt = 0 when FWD_STALL_CNT_EN is defined.
REQ-039 SHALL cover DEPTH = 5, NUM_RD = 3 with three reads hitting stages 2, 4 and none -> fwd_sel = {0, 4, 2}.

Source files
------------

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fwd_pkg
//  Brief   : Shared types and constants for the forwarding / hazard unit.
//            The tracker entry carries a fixed-width address field wide
//            enough for any supported ADDR_W; narrower addresses are
//            zero-extended on entry so comparisons stay exact.
//  Rev     : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // Width of one per-port forwarding select (stages 1..7 plus register file).
    localparam int FWD_SEL_W = 3;

    // Select value meaning "read from the register file".
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF = '0;

    // Storage width of the address field; ADDR_W must not exceed this.
    localparam int FWD_ADDR_MAX_W = 16;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_read;
        logic [FWD_ADDR_MAX_W-1:0] addr;
    } fwd_entry_t;

    // An entry can supply a forwarded value only if it really writes a
    // register other than r0.
    function automatic logic entry_writes(input fwd_entry_t e);
        return e.valid & e.reg_write & (e.addr != '0);
    endfunction

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
//  Module  : fwd_match
//  Brief   : Single read-port priority match over the stage tracker.
//            Produces the youngest matching stage (or register file) and a
//            not-ready flag when that youngest producer is a load whose
//            data is not yet available.
//  Rev     : 1.0  initial release
// ============================================================================
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int ADDR_W   = 5
) (
    input  fwd_entry_t [DEPTH-1:0]     entries_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    output logic [FWD_SEL_W-1:0]       sel_o,
    output logic                       not_ready_o
);

    logic [FWD_ADDR_MAX_W-1:0] rd_ext;

    assign rd_ext = FWD_ADDR_MAX_W'(rd_addr_i);

    // Scan oldest to youngest so the youngest match overwrites older ones;
    // readiness is judged on that youngest match only.
    always_comb begin
        sel_o       = FWD_SEL_RF;
        not_ready_o = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (entry_writes(entries_i[k-1]) && (entries_i[k-1].addr == rd_ext)) begin
                sel_o       = FWD_SEL_W'(k);
                not_ready_o = entries_i[k-1].mem_read && (k < LOAD_LAT);
            end
        end
    end

endmodule : fwd_match
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module  : forward_hazard_unit
//  Brief   : Operand forwarding select and load-use stall generation for an
//            in-order pipeline. A DEPTH-entry tracker mirrors the downstream
//            stages (entry 1 = EX); each read port gets a youngest-wins
//            forwarding select, and ID is stalled while a load producer is
//            still too young to forward.
//  Options : FWD_STALL_CNT_EN - adds a saturating 32-bit stall cycle counter
//            output (stall_cnt).
//  Rev     : 1.0  initial release
// ============================================================================
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic                          id_RegWrite,
    input  logic                          id_MemRead,
    input  logic [ADDR_W-1:0]             id_write_addr,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
    input  logic                          flush,
    output logic [NUM_RD*FWD_SEL_W-1:0]   fwd_sel,
    output logic                          stall,
    output logic                          bubble
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // Tracker: index 0 holds stage 1 (youngest), index DEPTH-1 the oldest.
    // ------------------------------------------------------------------
    fwd_entry_t [DEPTH-1:0] tracker_q;
    fwd_entry_t [DEPTH-1:0] tracker_d;

    logic [NUM_RD-1:0][FWD_SEL_W-1:0] port_sel;
    logic [NUM_RD-1:0]                port_not_ready;
    logic                             any_not_ready;
    logic                             issue;

    // Per-port youngest-wins match.
    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_port
            fwd_match #(
                .DEPTH    (DEPTH),
                .LOAD_LAT (LOAD_LAT),
                .ADDR_W   (ADDR_W)
            ) u_match (
                .entries_i   (tracker_q),
                .rd_addr_i   (rd_addr[p*ADDR_W +: ADDR_W]),
                .sel_o       (port_sel[p]),
                .not_ready_o (port_not_ready[p])
            );
        end
    endgenerate

    assign any_not_ready = |port_not_ready;

    // Hazard decision: flush beats stall, and reset (active low) masks
    // everything so nothing issues while it is held.
    always_comb begin
        stall  = reset & id_valid & ~flush & any_not_ready;
        issue  = reset & id_valid & ~flush & ~any_not_ready;
        bubble = ~issue;
    end

    // Forwarding selects are forced to the register file during reset so
    // uninitialised tracker contents never leak out.
    always_comb begin
        fwd_sel = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            fwd_sel[p*FWD_SEL_W +: FWD_SEL_W] = reset ? port_sel[p] : FWD_SEL_RF;
        end
    end

    // Next tracker: the ID instruction (or a bubble) enters stage 1 and
    // every older entry moves one stage down; the last one retires.
    always_comb begin
        tracker_d    = '0;
        if (issue) begin
            tracker_d[0].valid     = 1'b1;
            tracker_d[0].reg_write = id_RegWrite;
            tracker_d[0].mem_read  = id_MemRead;
            tracker_d[0].addr      = FWD_ADDR_MAX_W'(id_write_addr);
        end
        for (int i = 1; i < DEPTH; i++) begin
            tracker_d[i] = tracker_q[i-1];
        end
    end

    // Tracker register: downstream stages never stall, so it shifts every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tracker_q <= '0;
        end else begin
            tracker_q <= tracker_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : forward_hazard_unit
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_forward_hazard_unit
//  Brief   : Self-checking bench for forward_hazard_unit. A default
//            instance (NUM_RD=2, DEPTH=3, LOAD_LAT=2) runs scenario tables;
//            a second instance (NUM_RD=3, DEPTH=5) covers the wide config.
//            Expected outputs are queued when a row is driven and popped
//            when the outputs are sampled on the falling edge.
//  Options : FWD_STALL_CNT_EN - also checks stall_cnt.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_forward_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        reset;
    logic        id_valid, id_RegWrite, id_MemRead, flush;
    logic [4:0]  id_write_addr;
    logic [9:0]  rd_addr;
    logic [5:0]  fwd_sel;
    logic        stall, bubble;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] b_stall_cnt;
`endif

    // Wide instance
    logic        b_valid, b_rw, b_mr, b_flush;
    logic [4:0]  b_wa;
    logic [14:0] b_rd;
    logic [8:0]  b_sel;
    logic        b_stall, b_bubble;

    forward_hazard_unit #(.NUM_RD(2), .ADDR_W(5), .DEPTH(3), .LOAD_LAT(2)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_RegWrite   (id_RegWrite),
        .id_MemRead    (id_MemRead),
        .id_write_addr (id_write_addr),
        .rd_addr       (rd_addr),
        .flush         (flush),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .bubble        (bubble)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    forward_hazard_unit #(.NUM_RD(3), .ADDR_W(5), .DEPTH(5), .LOAD_LAT(2)) u_dut_wide (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (b_valid),
        .id_RegWrite   (b_rw),
        .id_MemRead    (b_mr),
        .id_write_addr (b_wa),
        .rd_addr       (b_rd),
        .flush         (b_flush),
        .fwd_sel       (b_sel),
        .stall         (b_stall),
        .bubble        (b_bubble)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt     (b_stall_cnt)
`endif
    );

    typedef struct {
        bit         rst, v, rw, mr, fl, es, eb;
        logic [4:0] wa, ra0, ra1;
        logic [2:0] e0, e1;
    } stim_t;

    typedef struct {
        bit         es, eb;
        logic [5:0] esel;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Row builder: rst, v, rw, mr, wa, ra0, ra1, flush, exp stall, exp bubble, exp sel0, exp sel1
    function automatic stim_t mk(input int rst, input int v, input int rw, input int mr,
                                 input int wa, input int ra0, input int ra1, input int fl,
                                 input int es, input int eb, input int e0, input int e1);
        stim_t s;
        s.rst = 1'(rst); s.v = 1'(v); s.rw = 1'(rw); s.mr = 1'(mr);
        s.wa = 5'(wa); s.ra0 = 5'(ra0); s.ra1 = 5'(ra1); s.fl = 1'(fl);
        s.es = 1'(es); s.eb = 1'(eb); s.e0 = 3'(e0); s.e1 = 3'(e1);
        return s;
    endfunction

    // Drive one row and queue its expected outputs.
    task automatic apply(input stim_t s);
        exp_t e;
        reset         = s.rst;
        id_valid      = s.v;
        id_RegWrite   = s.rw;
        id_MemRead    = s.mr;
        id_write_addr = s.wa;
        rd_addr       = {s.ra1, s.ra0};
        flush         = s.fl;
        e.es   = s.es;
        e.eb   = s.eb;
        e.esel = {s.e1, s.e0};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(0, 1,1,0, 3, 3,3, 0,  0,1, 0,0));
        rows.push_back(mk(0, 1,1,0, 3, 3,3, 0,  0,1, 0,0));
        rows.push_back(mk(1, 0,0,0, 0, 3,3, 0,  0,1, 0,0));
        rows.push_back(mk(1, 0,0,0, 0, 3,3, 0,  0,1, 0,0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (stall !== e.es || bubble !== e.eb || (!e.es && fwd_sel !== e.esel)) begin
                errors++;
                $display("FAIL reset[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, stall, bubble, fwd_sel, e.es, e.eb, e.esel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_chain();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(1, 1,1,0, 3, 1,2, 0,  0,0, 0,0));
        rows.push_back(mk(1, 1,1,0, 4, 3,5, 0,  0,0, 1,0));
        rows.push_back(mk(1, 1,0,0, 0, 3,4, 0,  0,0, 2,1));
        rows.push_back(mk(1, 0,0,0, 0, 3,4, 0,  0,1, 3,2));
        rows.push_back(mk(1, 0,0,0, 0, 3,4, 0,  0,1, 0,3));
        repeat (3) rows.push_back(mk(1, 0,0,0, 0, 0,0, 0,  0,1, 0,0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (stall !== e.es || bubble !== e.eb || (!e.es && fwd_sel !== e.esel)) begin
                errors++;
                $display("FAIL alu_chain[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, stall, bubble, fwd_sel, e.es, e.eb, e.esel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(1, 1,1,1, 8, 1,2, 0,  0,0, 0,0));   // lw r8
        rows.push_back(mk(1, 1,1,0, 9, 8,8, 0,  1,1, 0,0));   // add r9,r8,r8: stalls
        rows.push_back(mk(1, 1,1,0, 9, 8,8, 0,  0,0, 2,2));   // released, forward from stage 2
        rows.push_back(mk(1, 0,0,0, 0, 9,8, 0,  0,1, 1,3));
        repeat (3) rows.push_back(mk(1, 0,0,0, 0, 0,0, 0,  0,1, 0,0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (stall !== e.es || bubble !== e.eb || (!e.es && fwd_sel !== e.esel)) begin
                errors++;
                $display("FAIL load_use[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, stall, bubble, fwd_sel, e.es, e.eb, e.esel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest_wins();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(1, 1,1,0, 6, 0,0, 0,  0,0, 0,0));
        rows.push_back(mk(1, 1,1,0, 7, 0,0, 0,  0,0, 0,0));
        rows.push_back(mk(1, 1,1,0, 6, 6,6, 0,  0,0, 2,2));
        rows.push_back(mk(1, 0,0,0, 0, 6,6, 0,  0,1, 1,1));   // r6 at stages 1 and 3
        rows.push_back(mk(1, 1,1,0, 0, 0,0, 0,  0,0, 0,0));   // write r0
        rows.push_back(mk(1, 0,0,0, 0, 0,6, 0,  0,1, 0,3));   // r0 never matches
        rows.push_back(mk(1, 1,1,1, 0, 0,0, 0,  0,0, 0,0));   // load to r0
        rows.push_back(mk(1, 1,1,0, 5, 0,0, 0,  0,0, 0,0));   // no load-use on r0
        repeat (3) rows.push_back(mk(1, 0,0,0, 0, 0,0, 0,  0,1, 0,0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (stall !== e.es || bubble !== e.eb || (!e.es && fwd_sel !== e.esel)) begin
                errors++;
                $display("FAIL youngest[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, stall, bubble, fwd_sel, e.es, e.eb, e.esel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_stall();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(1, 1,1,1, 8, 1,2, 0,  0,0, 0,0));   // lw r8
        rows.push_back(mk(1, 1,1,0, 9, 8,8, 1,  0,1, 1,1));   // dependent flushed
        rows.push_back(mk(1, 1,0,0, 0, 9,8, 0,  0,0, 0,2));   // r9 never entered
        rows.push_back(mk(1, 0,0,0, 0, 9,8, 0,  0,1, 0,3));
        repeat (3) rows.push_back(mk(1, 0,0,0, 0, 0,0, 0,  0,1, 0,0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (stall !== e.es || bubble !== e.eb || (!e.es && fwd_sel !== e.esel)) begin
                errors++;
                $display("FAIL flush_stall[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, stall, bubble, fwd_sel, e.es, e.eb, e.esel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(1, 1,1,1, 8, 1,2, 0,  0,0, 0,0));   // lw r8
        rows.push_back(mk(1, 1,1,0, 9, 8,8, 0,  1,1, 0,0));   // stalled
        rows.push_back(mk(0, 1,1,0, 9, 8,8, 0,  0,1, 0,0));   // reset pulse
        rows.push_back(mk(1, 1,1,0, 9, 8,8, 0,  0,0, 0,0));   // tracker empty now
        repeat (3) rows.push_back(mk(1, 0,0,0, 0, 0,0, 0,  0,1, 0,0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (stall !== e.es || bubble !== e.eb || (!e.es && fwd_sel !== e.esel)) begin
                errors++;
                $display("FAIL reset_mid_stall[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, stall, bubble, fwd_sel, e.es, e.eb, e.esel);
            end
`ifdef FWD_STALL_CNT_EN
            // One stall cycle in test_load_use plus one here, then cleared.
            if (i == 2) begin
                checks++;
                if (stall_cnt !== 32'd2) begin
                    errors++;
                    $display("FAIL stall_cnt_before_reset: got %0d expected 2", stall_cnt);
                end
            end
            if (i == 3) begin
                checks++;
                if (stall_cnt !== 32'd0) begin
                    errors++;
                    $display("FAIL stall_cnt_after_reset: got %0d expected 0", stall_cnt);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide_config();
        logic [9:0] sbw[$];       // {stall, bubble, sel[8:0]} minus top bit: {stall, sel}
        logic [9:0] ew;
        logic [4:0] wa_tab [6];
        logic       v_tab  [6];
        logic [14:0] rd_tab [6];
        logic [9:0] exp_tab [6];
        wa_tab  = '{5'd10, 5'd0, 5'd11, 5'd0, 5'd0, 5'd0};
        v_tab   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rd_tab  = '{15'd0, 15'd0, 15'd0, 15'd0,
                    {5'd13, 5'd10, 5'd11}, {5'd13, 5'd10, 5'd11}};
        exp_tab = '{10'd0, 10'd0, 10'd0, 10'd0,
                    {1'b0, 3'd0, 3'd4, 3'd2}, {1'b0, 3'd0, 3'd5, 3'd3}};
        for (int i = 0; i < 6; i++) begin
            b_valid = v_tab[i];
            b_rw    = v_tab[i];
            b_mr    = 1'b0;
            b_wa    = wa_tab[i];
            b_rd    = rd_tab[i];
            b_flush = 1'b0;
            sbw.push_back(exp_tab[i]);
            @(negedge clk);
            ew = sbw.pop_front();
            checks++;
            if ({b_stall, b_sel} !== ew || b_bubble !== ~v_tab[i]) begin
                errors++;
                $display("FAIL wide[%0d]: got stall=%b bubble=%b sel=%h, expected stall=%b bubble=%b sel=%h",
                         i, b_stall, b_bubble, b_sel, ew[9], ~v_tab[i], ew[8:0]);
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        b_rd    = '0;
    endtask

    initial begin
        reset = 1'b0; id_valid = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0;
        id_write_addr = '0; rd_addr = '0; flush = 1'b0;
        b_valid = 1'b0; b_rw = 1'b0; b_mr = 1'b0; b_wa = '0; b_rd = '0; b_flush = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest_wins();
        test_flush_stall();
        test_reset_mid_stall();
        test_wide_config();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_forward_hazard_unit
`default_nettype wire
